microcode_sequencer_ctl: RTL and testbench

- Run-time controller for the team's microcoded state machine datapath.
- Replaces the fixed initial-block ROM with a writable control store, loaded through a valid/ready port.
- Sequences the micro-PC (uPC) using the existing word format and next-state rule.
- Adds start/stop/single-step/clear control and a saturating run-cycle counter for bring-up and test.

---
 rtl/microcode_sequencer_ctl.sv | 180 ++++++++++++++++++
 tb/tb_microcode_sequencer_ctl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer_ctl.sv
// rtl/microcode_sequencer_ctl.sv - writable-control-store micro-PC sequencer with run/stop/step/clear control
// Optional: define MICROCODE_PARITY_EN for per-word even parity and a sticky ParityErr output.
module microcode_sequencer_ctl #(
    parameter int ADDR_W = 3,
    parameter int OUT_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic                          Clock,
    input  logic                          ResetN,
    input  logic                          A,
    input  logic                          B,
    input  logic                          C,
    input  logic                          D,
    input  logic                          LoadValid,
    output logic                          LoadReady,
    input  logic [ADDR_W-1:0]             LoadAddr,
    input  logic [3+1+ADDR_W+OUT_W-1:0]   LoadData,
    input  logic                          Start,
    input  logic                          Stop,
    input  logic                          Step,
    input  logic                          Clear,
    output logic [OUT_W-1:0]              Outs,
    output logic [ADDR_W-1:0]             UPC,
    output logic                          Running,
    output logic                          StartErr,
    output logic [CNT_W-1:0]              CycleCount
`ifdef MICROCODE_PARITY_EN
    ,
    output logic                          ParityErr
`endif
);

    localparam int WORD_W = 3 + 1 + ADDR_W + OUT_W;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef MICROCODE_PARITY_EN
    localparam int STORE_W = WORD_W + 1;
`else
    localparam int STORE_W = WORD_W;
`endif

    typedef enum logic [1:0] {
        CTL_IDLE  = 2'd0,
        CTL_RUN   = 2'd1,
        CTL_PAUSE = 2'd2
    } ctl_t;

    ctl_t               ctl_q;
    logic [ADDR_W-1:0]  upc_q;
    logic [DEPTH-1:0]   loaded_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               start_err_q;
    logic [STORE_W-1:0] store_q [DEPTH];

    logic [WORD_W-1:0]  word;
    logic [2:0]         in_sel;
    logic               polarity;
    logic [ADDR_W-1:0]  cn_state;
    logic [OUT_W-1:0]   word_outs;
    logic [7:0]         test_inputs;
    logic               load_cn;
    logic [ADDR_W-1:0]  upc_adv_d;
    logic               wr_en;
    logic               fetch_bad;
    logic               perr_flag;

    assign word = store_q[upc_q][WORD_W-1:0];
    assign {in_sel, polarity, cn_state, word_outs} = word;

    // Input index 4..7 reads constant zero, giving unconditional branches.
    assign test_inputs = {4'b0000, D, C, B, A};
    assign load_cn     = test_inputs[in_sel] ^ polarity;
    assign upc_adv_d   = load_cn ? (upc_q + ADDR_W'(1)) : cn_state;

    assign LoadReady  = (ctl_q == CTL_IDLE) || (ctl_q == CTL_PAUSE);
    assign wr_en      = LoadValid && LoadReady;
    assign Running    = (ctl_q == CTL_RUN);
    assign Outs       = Running ? word_outs : '0;
    assign UPC        = upc_q;
    assign StartErr   = start_err_q;
    assign CycleCount = cnt_q;

`ifdef MICROCODE_PARITY_EN
    logic parity_err_q;
    assign fetch_bad = ^store_q[upc_q];
    assign perr_flag = parity_err_q;
    assign ParityErr = parity_err_q;
`else
    assign fetch_bad = 1'b0;
    assign perr_flag = 1'b0;
`endif

    // Control store is deliberately not reset; the loaded mask gates Start instead.
    always_ff @(posedge Clock) begin
        if (wr_en) begin
`ifdef MICROCODE_PARITY_EN
            store_q[LoadAddr] <= {^LoadData, LoadData};
`else
            store_q[LoadAddr] <= LoadData;
`endif
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            ctl_q        <= CTL_IDLE;
            upc_q        <= '0;
            loaded_q     <= '0;
            cnt_q        <= '0;
            start_err_q  <= 1'b0;
`ifdef MICROCODE_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            start_err_q <= 1'b0;
            if (wr_en) begin
                loaded_q[LoadAddr] <= 1'b1;
            end
            case (ctl_q)
                CTL_IDLE: begin
                    if (Clear) begin
                        upc_q <= '0;
`ifdef MICROCODE_PARITY_EN
                        parity_err_q <= 1'b0;
`endif
                    end else if (Start) begin
                        // Mask check sees the pre-write mask on a same-cycle load.
                        if ((&loaded_q) && !perr_flag) begin
                            ctl_q <= CTL_RUN;
                            upc_q <= '0;
                            cnt_q <= '0;
                        end else begin
                            start_err_q <= 1'b1;
                        end
                    end
                end
                CTL_RUN: begin
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (fetch_bad) begin
                        ctl_q <= CTL_PAUSE;
`ifdef MICROCODE_PARITY_EN
                        parity_err_q <= 1'b1;
`endif
                    end else begin
                        upc_q <= upc_adv_d;
                        if (Stop) begin
                            ctl_q <= CTL_PAUSE;
                        end
                    end
                end
                CTL_PAUSE: begin
                    if (Clear) begin
                        ctl_q <= CTL_IDLE;
                        upc_q <= '0;
`ifdef MICROCODE_PARITY_EN
                        parity_err_q <= 1'b0;
`endif
                    end else if (Start) begin
                        if (!perr_flag) begin
                            ctl_q <= CTL_RUN;
                        end else begin
                            start_err_q <= 1'b1;
                        end
                    end else if (Step) begin
                        if (fetch_bad) begin
`ifdef MICROCODE_PARITY_EN
                            parity_err_q <= 1'b1;
`endif
                        end else begin
                            upc_q <= upc_adv_d;
                        end
                    end
                end
                default: ctl_q <= CTL_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_microcode_sequencer_ctl.sv
// tb/tb_microcode_sequencer_ctl.sv - directed self-checking bench for microcode_sequencer_ctl
// Parity scenario is compiled only when MICROCODE_PARITY_EN is defined.
module tb_microcode_sequencer_ctl;

    logic        Clock;
    logic        ResetN;
    logic        A, B, C, D;
    logic        LoadValid;
    logic        LoadReady;
    logic [2:0]  LoadAddr;
    logic [9:0]  LoadData;
    logic        Start, Stop, Step, Clear;
    logic [2:0]  Outs;
    logic [2:0]  UPC;
    logic        Running;
    logic        StartErr;
    logic [15:0] CycleCount;
`ifdef MICROCODE_PARITY_EN
    logic        ParityErr;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [9:0] tbl [8];

    microcode_sequencer_ctl #(.ADDR_W(3), .OUT_W(3), .CNT_W(16)) dut (
        .Clock(Clock), .ResetN(ResetN), .A(A), .B(B), .C(C), .D(D),
        .LoadValid(LoadValid), .LoadReady(LoadReady), .LoadAddr(LoadAddr), .LoadData(LoadData),
        .Start(Start), .Stop(Stop), .Step(Step), .Clear(Clear),
        .Outs(Outs), .UPC(UPC), .Running(Running), .StartErr(StartErr), .CycleCount(CycleCount)
`ifdef MICROCODE_PARITY_EN
        , .ParityErr(ParityErr)
`endif
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic tick();
        @(negedge Clock);
    endtask

    task automatic load_word(input logic [2:0] a, input logic [9:0] w);
        LoadValid = 1'b1; LoadAddr = a; LoadData = w;
        tick();
        LoadValid = 1'b0;
    endtask

    task automatic load_range(input int n);
        for (int i = 0; i < n; i++) load_word(3'(i), tbl[i]);
    endtask

    task automatic halt_and_clear();
        Stop = 1'b1; tick(); Stop = 1'b0;
        Clear = 1'b1; tick(); Clear = 1'b0;
    endtask

    task automatic test_reset();
        ResetN = 1'b0;
        tick();
        n_checks++; if (Running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %0b expected 0", Running); end
        n_checks++; if (UPC !== 3'd0) begin n_fail++; $display("FAIL reset_upc: got %0d expected 0", UPC); end
        n_checks++; if (Outs !== 3'b000) begin n_fail++; $display("FAIL reset_outs: got %b expected 000", Outs); end
        n_checks++; if (StartErr !== 1'b0) begin n_fail++; $display("FAIL reset_starterr: got %0b expected 0", StartErr); end
        n_checks++; if (CycleCount !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", CycleCount); end
        n_checks++; if (LoadReady !== 1'b1) begin n_fail++; $display("FAIL reset_loadready: got %0b expected 1", LoadReady); end
        ResetN = 1'b1;
        tick();
    endtask

    task automatic test_run_a0b0();
        logic [2:0] exp_upc [4];
        logic [2:0] exp_out [4];
        exp_upc = '{3'd0, 3'd1, 3'd2, 3'd6};
        exp_out = '{3'b100, 3'b000, 3'b000, 3'b101};
        load_range(8);
        A = 0; B = 0; C = 0; D = 0;
        Start = 1'b1; tick(); Start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (UPC !== exp_upc[i]) begin n_fail++; $display("FAIL a0b0_upc[%0d]: got %0d expected %0d", i, UPC, exp_upc[i]); end
            n_checks++; if (Outs !== exp_out[i]) begin n_fail++; $display("FAIL a0b0_outs[%0d]: got %b expected %b", i, Outs, exp_out[i]); end
            n_checks++; if (CycleCount !== 16'(i)) begin n_fail++; $display("FAIL a0b0_count[%0d]: got %0d expected %0d", i, CycleCount, i); end
            if (i < 3) tick();
        end
        C = 1'b1; tick();
        n_checks++; if (UPC !== 3'd7) begin n_fail++; $display("FAIL c1_upc: got %0d expected 7", UPC); end
        n_checks++; if (Outs !== 3'b001) begin n_fail++; $display("FAIL c1_outs: got %b expected 001", Outs); end
        C = 1'b0;
        halt_and_clear();
    endtask

    task automatic test_hold_a();
        A = 1; B = 0; C = 0; D = 0;
        Start = 1'b1; tick(); Start = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (UPC !== 3'd1 || Outs !== 3'b000) begin n_fail++; $display("FAIL hold_a[%0d]: got upc %0d outs %b expected upc 1 outs 000", i, UPC, Outs); end
            tick();
        end
        A = 0; tick();
        n_checks++; if (UPC !== 3'd2) begin n_fail++; $display("FAIL release_a_upc: got %0d expected 2", UPC); end
        B = 1; tick();
        n_checks++; if (UPC !== 3'd3) begin n_fail++; $display("FAIL b1_upc: got %0d expected 3", UPC); end
        tick();
        n_checks++; if (UPC !== 3'd4 || Outs !== 3'b110) begin n_fail++; $display("FAIL d0_state: got upc %0d outs %b expected upc 4 outs 110", UPC, Outs); end
        B = 0;
        halt_and_clear();
    endtask

    task automatic test_start_err();
        ResetN = 1'b0; tick(); ResetN = 1'b1; tick();
        load_range(7);
        Start = 1'b1; tick(); Start = 1'b0;
        n_checks++; if (StartErr !== 1'b1 || Running !== 1'b0) begin n_fail++; $display("FAIL partial_start: got starterr %0b running %0b expected 1 0", StartErr, Running); end
        tick();
        n_checks++; if (StartErr !== 1'b0) begin n_fail++; $display("FAIL starterr_pulse: got %0b expected 0", StartErr); end
        Start = 1'b1; LoadValid = 1'b1; LoadAddr = 3'd7; LoadData = tbl[7];
        tick();
        Start = 1'b0; LoadValid = 1'b0;
        n_checks++; if (StartErr !== 1'b1 || Running !== 1'b0) begin n_fail++; $display("FAIL premask_start: got starterr %0b running %0b expected 1 0", StartErr, Running); end
        Start = 1'b1; tick(); Start = 1'b0;
        n_checks++; if (Running !== 1'b1 || StartErr !== 1'b0 || UPC !== 3'd0) begin n_fail++; $display("FAIL full_start: got running %0b starterr %0b upc %0d expected 1 0 0", Running, StartErr, UPC); end
        halt_and_clear();
    endtask

    task automatic test_stop_step();
        A = 0; B = 0; C = 0; D = 0;
        Start = 1'b1; tick(); Start = 1'b0;
        tick();
        Stop = 1'b1; tick(); Stop = 1'b0;
        n_checks++; if (UPC !== 3'd2 || Running !== 1'b0) begin n_fail++; $display("FAIL stop_state: got upc %0d running %0b expected 2 0", UPC, Running); end
        n_checks++; if (Outs !== 3'b000 || LoadReady !== 1'b1) begin n_fail++; $display("FAIL pause_outs: got outs %b loadready %0b expected 000 1", Outs, LoadReady); end
        n_checks++; if (CycleCount !== 16'd2) begin n_fail++; $display("FAIL stop_count: got %0d expected 2", CycleCount); end
        Step = 1'b1; #1;
        n_checks++; if (Outs !== 3'b000) begin n_fail++; $display("FAIL step_outs: got %b expected 000", Outs); end
        tick(); Step = 1'b0;
        n_checks++; if (UPC !== 3'd6 || Running !== 1'b0) begin n_fail++; $display("FAIL step_upc: got upc %0d running %0b expected 6 0", UPC, Running); end
        Start = 1'b1; tick(); Start = 1'b0;
        n_checks++; if (Running !== 1'b1 || UPC !== 3'd6 || CycleCount !== 16'd2) begin n_fail++; $display("FAIL resume: got running %0b upc %0d count %0d expected 1 6 2", Running, UPC, CycleCount); end
        tick();
        n_checks++; if (UPC !== 3'd0 || CycleCount !== 16'd3) begin n_fail++; $display("FAIL resume_next: got upc %0d count %0d expected 0 3", UPC, CycleCount); end
        halt_and_clear();
    endtask

    task automatic test_back_to_back();
        A = 0; B = 0;
        Start = 1'b1; tick();
        Stop = 1'b1; tick(); Stop = 1'b0; Start = 1'b0;
        n_checks++; if (Running !== 1'b0 || UPC !== 3'd1) begin n_fail++; $display("FAIL stop_over_start: got running %0b upc %0d expected 0 1", Running, UPC); end
        Step = 1'b1; tick();
        n_checks++; if (UPC !== 3'd2) begin n_fail++; $display("FAIL held_step1: got %0d expected 2", UPC); end
        B = 1'b1; tick(); Step = 1'b0; B = 1'b0;
        n_checks++; if (UPC !== 3'd3) begin n_fail++; $display("FAIL held_step2: got %0d expected 3", UPC); end
        Clear = 1'b1; Start = 1'b1; Step = 1'b1; tick(); Clear = 1'b0; Start = 1'b0; Step = 1'b0;
        n_checks++; if (Running !== 1'b0 || UPC !== 3'd0 || StartErr !== 1'b0) begin n_fail++; $display("FAIL clear_priority: got running %0b upc %0d starterr %0b expected 0 0 0", Running, UPC, StartErr); end
        Start = 1'b1; tick(); Start = 1'b0;
        Clear = 1'b1; tick(); Clear = 1'b0;
        n_checks++; if (Running !== 1'b1 || UPC !== 3'd1) begin n_fail++; $display("FAIL clear_in_run: got running %0b upc %0d expected 1 1", Running, UPC); end
        halt_and_clear();
    endtask

    task automatic test_load_in_run();
        A = 0; B = 0; C = 0;
        Start = 1'b1; tick(); Start = 1'b0;
        LoadValid = 1'b1; LoadAddr = 3'd6; LoadData = 10'h3FF; #1;
        n_checks++; if (LoadReady !== 1'b0) begin n_fail++; $display("FAIL run_loadready: got %0b expected 0", LoadReady); end
        tick(); LoadValid = 1'b0;
        tick(); tick();
        n_checks++; if (UPC !== 3'd6 || Outs !== 3'b101) begin n_fail++; $display("FAIL store_kept: got upc %0d outs %b expected 6 101", UPC, Outs); end
        ResetN = 1'b0; #1;
        n_checks++; if (UPC !== 3'd0 || Running !== 1'b0 || Outs !== 3'b000) begin n_fail++; $display("FAIL async_reset: got upc %0d running %0b outs %b expected 0 0 000", UPC, Running, Outs); end
        ResetN = 1'b1;
        tick();
        Start = 1'b1; tick(); Start = 1'b0;
        n_checks++; if (StartErr !== 1'b1 || Running !== 1'b0) begin n_fail++; $display("FAIL reload_needed: got starterr %0b running %0b expected 1 0", StartErr, Running); end
        tick();
    endtask

`ifdef MICROCODE_PARITY_EN
    task automatic test_parity();
        load_range(8);
        dut.store_q[2] = dut.store_q[2] ^ 11'h001;
        A = 0; B = 0;
        Start = 1'b1; tick(); Start = 1'b0;
        tick(); tick(); tick();
        n_checks++; if (Running !== 1'b0 || UPC !== 3'd2 || ParityErr !== 1'b1) begin n_fail++; $display("FAIL parity_trap: got running %0b upc %0d perr %0b expected 0 2 1", Running, UPC, ParityErr); end
        Clear = 1'b1; tick(); Clear = 1'b0;
        n_checks++; if (ParityErr !== 1'b0 || Running !== 1'b0 || UPC !== 3'd0) begin n_fail++; $display("FAIL parity_clear: got perr %0b running %0b upc %0d expected 0 0 0", ParityErr, Running, UPC); end
    endtask
`endif

    initial begin
        tbl[0] = {3'd4, 1'b1, 3'd0, 3'b100};
        tbl[1] = {3'd0, 1'b1, 3'd1, 3'b000};
        tbl[2] = {3'd1, 1'b0, 3'd6, 3'b000};
        tbl[3] = {3'd3, 1'b1, 3'd5, 3'b010};
        tbl[4] = {3'd4, 1'b1, 3'd0, 3'b110};
        tbl[5] = {3'd4, 1'b0, 3'd0, 3'b011};
        tbl[6] = {3'd2, 1'b0, 3'd0, 3'b101};
        tbl[7] = {3'd4, 1'b0, 3'd0, 3'b001};
        A = 0; B = 0; C = 0; D = 0;
        LoadValid = 0; LoadAddr = '0; LoadData = '0;
        Start = 0; Stop = 0; Step = 0; Clear = 0;
        test_reset();
        test_run_a0b0();
        test_hold_a();
        test_start_err();
        test_stop_step();
        test_back_to_back();
        test_load_in_run();
`ifdef MICROCODE_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
